// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath:
// opcode in, Moore control strobes and mux selects out.
interface main_fsm_if;
    logic [6:0] op;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    modport master (
        output op,
        input  pc_update, branch, ir_write, reg_write, mem_write, adr_src,
        input  result_src, alu_src_a, alu_src_b, alu_op
    );

    modport slave (
        input  op,
        output pc_update, branch, ir_write, reg_write, mem_write, adr_src,
        output result_src, alu_src_a, alu_src_b, alu_op
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: Moore outputs decoded from the state,
// opcode consulted only in DECODE and MEMADR.
module main_fsm (
    input  logic       clk,
    input  logic       reset_n,
    main_fsm_if.slave  bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = FETCH;
        bus.pc_update  = 1'b0;
        bus.branch     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;

        case (state_q)
            FETCH: begin
                state_d        = DECODE;
                bus.ir_write   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.pc_update  = 1'b1;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d       = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                state_d     = MEMWB;
                bus.adr_src = 1'b1;
            end
            MEMWB: begin
                state_d        = FETCH;
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                state_d       = FETCH;
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXECUTER: begin
                state_d       = ALUWB;
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
            end
            EXECUTEI: begin
                state_d       = ALUWB;
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
            end
            ALUWB: begin
                state_d       = FETCH;
                bus.reg_write = 1'b1;
            end
            BEQ: begin
                state_d       = FETCH;
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.branch    = 1'b1;
            end
            JAL: begin
                state_d       = ALUWB;
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_update = 1'b1;
            end
            // Unused encodings fall back to FETCH with all strobes low.
            default: state_d = FETCH;
        endcase
    end
endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: instruction-level phase model feeds an
// expectation queue, a negedge monitor compares the control vector.
module tb_main_fsm;
    logic clk;
    logic reset_n;

    main_fsm_if bus ();

    main_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_update, branch, ir_write, reg_write, mem_write, adr_src,
    //  result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]}
    localparam logic [13:0] V_FETCH    = 14'b1_0_1_0_0_0_10_00_10_00;
    localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_0_00_01_01_00;
    localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_0_0_00_10_01_00;
    localparam logic [13:0] V_MEMREAD  = 14'b0_0_0_0_0_1_00_00_00_00;
    localparam logic [13:0] V_MEMWB    = 14'b0_0_0_1_0_0_01_00_00_00;
    localparam logic [13:0] V_MEMWRITE = 14'b0_0_0_0_1_1_00_00_00_00;
    localparam logic [13:0] V_EXECR    = 14'b0_0_0_0_0_0_00_10_00_10;
    localparam logic [13:0] V_EXECI    = 14'b0_0_0_0_0_0_00_10_01_10;
    localparam logic [13:0] V_ALUWB    = 14'b0_0_0_1_0_0_00_00_00_00;
    localparam logic [13:0] V_BEQ      = 14'b0_1_0_0_0_0_00_10_00_01;
    localparam logic [13:0] V_JAL      = 14'b1_0_0_0_0_0_00_01_10_00;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit mon_en    = 1'b0;

    logic [13:0] exp_q[$];
    string       name_q[$];

    logic [13:0] plan_v[$];
    bit          plan_op[$];
    string       plan_nm[$];

    function automatic logic [13:0] dut_vec();
        return {bus.pc_update, bus.branch, bus.ir_write, bus.reg_write,
                bus.mem_write, bus.adr_src, bus.result_src, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op};
    endfunction

    function automatic void check(string nm, logic [13:0] act, logic [13:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endfunction

    function automatic void add_phase(logic [13:0] v, bit uses_op, string nm);
        plan_v.push_back(v);
        plan_op.push_back(uses_op);
        plan_nm.push_back(nm);
    endfunction

    // Instruction-level reference: phase list per instruction class.
    function automatic void model(logic [6:0] opc);
        plan_v.delete();
        plan_op.delete();
        plan_nm.delete();
        add_phase(V_FETCH, 1'b0, "fetch");
        add_phase(V_DECODE, 1'b1, "decode");
        if (opc == OP_LW) begin
            add_phase(V_MEMADR, 1'b1, "lw_memadr");
            add_phase(V_MEMREAD, 1'b0, "lw_memread");
            add_phase(V_MEMWB, 1'b0, "lw_memwb");
        end else if (opc == OP_SW) begin
            add_phase(V_MEMADR, 1'b1, "sw_memadr");
            add_phase(V_MEMWRITE, 1'b0, "sw_memwrite");
        end else if (opc == OP_R) begin
            add_phase(V_EXECR, 1'b0, "r_exec");
            add_phase(V_ALUWB, 1'b0, "r_aluwb");
        end else if (opc == OP_I) begin
            add_phase(V_EXECI, 1'b0, "i_exec");
            add_phase(V_ALUWB, 1'b0, "i_aluwb");
        end else if (opc == OP_BEQ) begin
            add_phase(V_BEQ, 1'b0, "beq");
        end else if (opc == OP_JAL) begin
            add_phase(V_JAL, 1'b0, "jal");
            add_phase(V_ALUWB, 1'b0, "jal_aluwb");
        end
    endfunction

    function automatic void expect_v(logic [13:0] v, string nm);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endfunction

    // Called at posedge+1; leaves at posedge+1 of the next instruction's FETCH.
    // If abort_at >= 0, reset is pulsed low after that phase is checked.
    task automatic issue(input logic [6:0] opc, input int abort_at);
        model(opc);
        for (int k = 0; k < plan_v.size(); k++) begin
            bus.op = plan_op[k] ? opc : 7'($urandom);
            expect_v(plan_v[k], plan_nm[k]);
            if (k == abort_at) begin
                @(negedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk);
                #1;
                bus.op = 7'($urandom);
                expect_v(V_FETCH, "abort_fetch");
                @(posedge clk);
                #1;
                expect_v(V_FETCH, "abort_hold");
                @(posedge clk);
                #1 reset_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] legal [6];
        int         sel;
        legal[0] = OP_LW;
        legal[1] = OP_SW;
        legal[2] = OP_R;
        legal[3] = OP_I;
        legal[4] = OP_BEQ;
        legal[5] = OP_JAL;
        sel = $urandom_range(0, 7);
        if (sel < 6) return legal[sel];
        if (sel == 6) return 7'($urandom);
        return OP_BAD;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL queue_underflow: got output %b expected no pending entry", dut_vec());
            end else begin
                check(name_q.pop_front(), dut_vec(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        bus.op  = 7'd0;
        #2 reset_n = 1'b0;
        #1 check("reset_async", dut_vec(), V_FETCH);
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_hold", dut_vec(), V_FETCH);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("release_decode", dut_vec(), V_DECODE);
        bus.op = OP_R;
        @(posedge clk);
        #1 check("pre_reset_exec", dut_vec(), V_EXECR);
        #1 reset_n = 1'b0;
        #1 check("reset_midcycle", dut_vec(), V_FETCH);
        @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        issue(OP_LW, -1);
        issue(OP_SW, -1);
        issue(OP_R, -1);
        issue(OP_I, -1);
        issue(OP_BEQ, -1);
        issue(OP_JAL, -1);
        issue(OP_BAD, -1);
        issue(OP_LW, 3);
        issue(OP_JAL, -1);
        for (int n = 0; n < 80; n++) begin
            issue(pick_op(), ($urandom_range(0, 9) == 0) ? 1 : -1);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port op, input, 7 bits: opcode field of the instruction register.
REQ-004 The block SHALL have port pc_update, output, 1 bit: unconditional PC write.
REQ-005 The block SHALL have port branch, output, 1 bit: conditional PC write (qualified by zero outside this block).
REQ-006 The block SHALL have port ir_write, output, 1 bit: load instruction and old-PC registers.
REQ-007 The block SHALL have port reg_write, output, 1 bit: register file write enable.
REQ-008 The block SHALL have port mem_write, output, 1 bit: data memory write enable.
REQ-009 The block SHALL have port adr_src, output, 1 bit: memory address select (0 = PC, 1 = result).
REQ-010 The block SHALL have port result_src, output, 2 bits: result mux select (00 = ALU out reg, 01 = data reg, 10 = ALU result).
REQ-011 The block SHALL have port alu_src_a, output, 2 bits: ALU A select (00 = PC, 01 = old PC, 10 = rs1 reg).
REQ-012 The block SHALL have port alu_src_b, output, 2 bits: ALU B select (00 = rs2 reg, 01 = immediate, 10 = constant 4).
REQ-013 The block SHALL have port alu_op, output, 2 bits: ALU decoder class (00 = add, 01 = subtract, 10 = decode funct3/funct7).

Function
REQ-014 The block SHALL be a Moore FSM: all outputs are a combinational function of the current state only.
REQ-015 The state set SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; the state register is 4 bits wide.
REQ-016 Any output not listed for a state SHALL be driven 0.
REQ-017 FETCH SHALL drive adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
REQ-018 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00.
REQ-019 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00.
REQ-020 MEMREAD SHALL drive result_src=00, adr_src=1.
REQ-021 MEMWB SHALL drive result_src=01, reg_write=1.
REQ-022 MEMWRITE SHALL drive result_src=00, adr_src=1, mem_write=1.
REQ-023 EXECUTER SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10.
REQ-024 EXECUTEI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10.
REQ-025 ALUWB SHALL drive result_src=00, reg_write=1.
REQ-026 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
REQ-027 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
REQ-028 FETCH SHALL always transition to DECODE.
REQ-029 From DECODE, the next state SHALL be selected by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other value -> FETCH (the instruction is a no-op; no write strobe is asserted).
REQ-030 From MEMADR, op 0000011 SHALL transition to MEMREAD, and any other op SHALL transition to MEMWRITE.
REQ-031 The remaining transitions SHALL be fixed:
- MEMREAD -> MEMWB
- EXECUTER -> ALUWB
- EXECUTEI -> ALUWB
- JAL -> ALUWB
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH
REQ-032 Instruction latency SHALL be, in cycles including FETCH:
- lw 5
- sw, R-type, I-type ALU and jal 4
- beq 3
- unsupported opcode 2
REQ-033 The block SHALL sample op only in DECODE and MEMADR; op changes in any other state SHALL have no effect.
REQ-034 An unreachable state encoding SHALL transition to FETCH on the next clock edge.
REQ-035 At most one of reg_write and mem_write SHALL be 1 in any state, and pc_update and branch SHALL never both be 1.

Reset
REQ-036 While reset_n=0, the state SHALL be FETCH immediately, independent of clk.
REQ-037 While reset_n=0, the outputs SHALL equal the FETCH values (ir_write=1, pc_update=1, alu_src_b=10, result_src=10, all other outputs 0).
REQ-038 Reset asserted in any state SHALL abort the instruction in progress with no further write strobes.
REQ-039 After reset_n rises, the first rising clk edge SHALL move the FSM to DECODE.

Verification
REQ-040 The bench SHALL check reset: reset_n=0 mid-clock -> outputs switch to FETCH values before the next edge; release -> DECODE after one edge.
REQ-041 The bench SHALL check lw: op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_write=1 only in cycle 5 with result_src=01.
REQ-042 The bench SHALL check sw: op=0100011 -> mem_write=1 only in cycle 4 with adr_src=1; reg_write stays 0 throughout.
REQ-043 The bench SHALL check R-type and I-type: op=0110011 -> alu_op=10 with alu_src_b=00 in cycle 3; op=0010011 -> alu_src_b=01 in cycle 3; both give reg_write=1 in cycle 4.
REQ-044 The bench SHALL check beq and jal: op=1100011 -> branch=1 with alu_op=01 in cycle 3, then FETCH; op=1101111 -> pc_update=1 with alu_src_a=01 in cycle 3, then reg_write=1 in cycle 4.
REQ-045 The bench SHALL check the illegal opcode and mid-operation reset: op=1111111 -> DECODE then FETCH with no strobes; reset_n=0 during MEMREAD -> no MEMWB cycle follows.
